encoder_8x3_seq: RTL and testbench
==================================

ENCODER_8X3_SEQ -- requirements
Module: encoder_8x3_seq

Interface
REQ-001 Parameter HIGH_FIRST, default 1: 1 gives D[7] highest priority, 0 gives D[0] highest priority.
REQ-002 CLK    input   1  sole clock, all state updates on rising edge.
REQ-003 RST_N  input   1  reset, asynchronous, active-low.
REQ-004 D      input   8  request lines, one bit per code 0..7, multi-hot allowed.
REQ-005 EN     input   1  enable for request capture; when low, D is ignored.
REQ-006 RDY    input   1  consumer ready; a grant completes on a rising edge with V=1 and RDY=1.
REQ-007 CLR_OVF input  1  synchronous clear of OVF.
REQ-008 A      output  1  code bit 2 (MSB) of the granted index.
REQ-009 B      output  1  code bit 1 of the granted index.
REQ-010 C      output  1  code bit 0 (LSB) of the granted index.
REQ-011 V      output  1  code valid; {A,B,C} is meaningful only while V=1.
REQ-012 PEND   output  8  registered pending-request vector.
REQ-013 OVF    output  1  sticky flag: a request was lost because its bit was already pending.

Function
REQ-014 The pending register PEND shall capture requests: each edge, PEND[i] <= 1 if (EN & D[i]); else PEND[i] <= 0 if the bit is being cleared by a completing grant; else it holds.
REQ-015 When a request and a grant clear hit the same bit in the same cycle, the set shall win: the bit stays pending and OVF is not set.
REQ-016 OVF shall set on an edge where EN & D[i] & PEND[i] for any i, and that bit i is not being cleared in the same cycle.
REQ-017 CLR_OVF shall clear OVF on the next edge; if a set condition occurs in the same cycle, the set shall win.
REQ-018 The FSM shall have two states, IDLE and GRANT.
REQ-019 In IDLE with PEND != 0, on the next edge the FSM shall load {A,B,C} with the highest-priority pending index, set V=1, and go to GRANT.
REQ-020 In IDLE with PEND == 0, the FSM shall remain in IDLE with V=0.
REQ-021 In GRANT, {A,B,C} and V shall be held stable until RDY=1, regardless of new higher-priority requests arriving.
REQ-022 In GRANT with RDY=1, on the edge the FSM shall clear PEND[{A,B,C}] (subject to REQ-015), drive V=0, and return to IDLE.
REQ-023 Latency: a request captured at edge N appears in PEND after edge N. If the FSM is idle, V=1 follows after edge N+1. Maximum throughput is one grant per 2 cycles.
REQ-024 RDY while V=0 shall have no effect.
REQ-025 The priority choice shall use the registered PEND only, never D directly.
REQ-026 When EN is low, in-progress grants and pending service shall continue; only new captures are blocked.
REQ-027 {A,B,C} shall retain the last granted code while V=0. Consumers shall ignore it.

Reset
REQ-028 While RST_N=0, the block shall immediately (asynchronously) force PEND=8'h00, V=0, {A,B,C}=3'b000, OVF=0, and state IDLE.
REQ-029 Reset asserted mid-grant shall discard the grant and all pending requests; no clear or grant completes.
REQ-030 After RST_N rises, the first capture shall occur at the first rising CLK edge.

Verification
REQ-031 Reset, then D=8'h00, EN=1 for 5 cycles: expect V=0, PEND=8'h00, OVF=0 throughout.
REQ-032 HIGH_FIRST=1, one-cycle pulse D=8'b1010_0100, EN=1, RDY=1: expect grants in order 7 (ABC=111), 5 (101), 2 (010), each V pulse 1 cycle, then PEND=8'h00.
REQ-033 HIGH_FIRST=0, same stimulus: expect grant order 2, 5, 7.
REQ-034 Hold RDY=0 during grant of 3, then pulse D[6]: expect ABC=011 held stable with V=1. On RDY=1 expect 3 to complete, then grant 6.
REQ-035 Pending D[4] pulsed again with no grant in flight: expect OVF=1. Then CLR_OVF pulse: expect OVF=0. Then D[4] pulsed on the same edge as its grant completes with RDY=1: expect PEND[4]=1 and OVF=0.
REQ-036 RST_N low mid-grant with PEND=8'h81: expect immediately V=0, PEND=8'h00, ABC=000, OVF=0. After release with D=0, expect no grant.

Source files
------------

// File: rtl/encoder_8x3_seq.sv
// Sequential 8-to-3 priority encoder with request capture and a grant handshake.
//
// Requests on D are captured into a pending register (PEND) while EN is high.
// A two-state FSM picks the highest-priority pending bit and presents its
// index on {A,B,C} with V=1. The code is held until the consumer accepts it
// with RDY=1, which clears that pending bit. OVF is a sticky flag that records
// a request arriving for a bit that was already pending.
//
// Parameters:
//   HIGH_FIRST  1: D[7] has the highest priority, 0: D[0] has the highest.
// Ports:
//   CLK      clock, rising edge
//   RST_N    asynchronous active-low reset
//   D[7:0]   request lines, multi-hot allowed
//   EN       capture enable for D
//   RDY      consumer ready, completes a grant while V=1
//   CLR_OVF  synchronous clear of OVF
//   A,B,C    granted index, A is the MSB
//   V        grant valid
//   PEND     pending-request vector
//   OVF      sticky lost-request flag
module encoder_8x3_seq #(
  parameter bit HIGH_FIRST = 1'b1
) (
  input  logic       CLK,
  input  logic       RST_N,
  input  logic [7:0] D,
  input  logic       EN,
  input  logic       RDY,
  input  logic       CLR_OVF,
  output logic       A,
  output logic       B,
  output logic       C,
  output logic       V,
  output logic [7:0] PEND,
  output logic       OVF
);

  typedef enum logic [0:0] {StIdle, StGrant} state_e;

  state_e     state_q, state_d;
  logic [7:0] pend_q, pend_d;
  logic [2:0] code_q, code_d;
  logic       ovf_q, ovf_d;

  logic [7:0] cap;
  logic [7:0] clr;
  logic [2:0] pick;
  logic       ovf_set;

  // Priority choice looks only at the registered pending vector.
  // The last match in the scan order wins, so scan towards the top priority.
  always_comb begin
    pick = 3'd0;
    if (HIGH_FIRST) begin
      for (int i = 0; i < 8; i++) begin
        if (pend_q[i]) pick = 3'(i);
      end
    end else begin
      for (int i = 7; i >= 0; i--) begin
        if (pend_q[i]) pick = 3'(i);
      end
    end
  end

  // Capture, grant-clear and overflow detection.
  always_comb begin
    cap = {8{EN}} & D;
    clr = 8'h00;
    if (state_q == StGrant && RDY) clr[code_q] = 1'b1;
    // A new request on a bit being cleared this edge re-arms it (set wins).
    pend_d  = (pend_q & ~clr) | cap;
    // Only a request that collides with a bit staying pending is lost.
    ovf_set = |(cap & pend_q & ~clr);
    if (ovf_set) begin
      ovf_d = 1'b1;
    end else if (CLR_OVF) begin
      ovf_d = 1'b0;
    end else begin
      ovf_d = ovf_q;
    end
  end

  // FSM state register.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Datapath registers.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      pend_q <= 8'h00;
      code_q <= 3'd0;
      ovf_q  <= 1'b0;
    end else begin
      pend_q <= pend_d;
      code_q <= code_d;
      ovf_q  <= ovf_d;
    end
  end

  // FSM next-state. The code is only reloaded when a new grant starts, so it
  // stays stable through the grant and keeps the last value while idle.
  always_comb begin
    state_d = state_q;
    code_d  = code_q;
    unique case (state_q)
      StIdle: begin
        if (|pend_q) begin
          state_d = StGrant;
          code_d  = pick;
        end
      end
      StGrant: begin
        if (RDY) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // FSM outputs.
  always_comb begin
    V         = (state_q == StGrant);
    {A, B, C} = code_q;
    PEND      = pend_q;
    OVF       = ovf_q;
  end

endmodule

// File: tb/tb_encoder_8x3_seq.sv
module tb_encoder_8x3_seq;

  logic       clk;
  logic       rst_n;
  logic [7:0] d;
  logic       en;
  logic       rdy;
  logic       clr_ovf;

  logic       a_h, b_h, c_h, v_h, ovf_h;
  logic [7:0] pend_h;
  logic       a_l, b_l, c_l, v_l, ovf_l;
  logic [7:0] pend_l;

  int n_cmp;
  int n_bad;

  // Index 0: HIGH_FIRST=1 instance, index 1: HIGH_FIRST=0 instance.
  logic [12:0] obs [2];

  // Behavioural model: pending set, grant in flight, granted code, sticky flag.
  bit [7:0] m_pend [2];
  bit       m_busy [2];
  bit [2:0] m_code [2];
  bit       m_ovf  [2];

  encoder_8x3_seq #(.HIGH_FIRST(1'b1)) dut_h (
    .CLK(clk), .RST_N(rst_n), .D(d), .EN(en), .RDY(rdy), .CLR_OVF(clr_ovf),
    .A(a_h), .B(b_h), .C(c_h), .V(v_h), .PEND(pend_h), .OVF(ovf_h)
  );

  encoder_8x3_seq #(.HIGH_FIRST(1'b0)) dut_l (
    .CLK(clk), .RST_N(rst_n), .D(d), .EN(en), .RDY(rdy), .CLR_OVF(clr_ovf),
    .A(a_l), .B(b_l), .C(c_l), .V(v_l), .PEND(pend_l), .OVF(ovf_l)
  );

  always_comb begin
    obs[0] = {a_h, b_h, c_h, v_h, pend_h, ovf_h};
    obs[1] = {a_l, b_l, c_l, v_l, pend_l, ovf_l};
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic bit [12:0] exp_vec(int k);
    return {m_code[k], m_busy[k], m_pend[k], m_ovf[k]};
  endfunction

  // Highest-priority set index: top-down search for HIGH_FIRST, bottom-up otherwise.
  function automatic bit [2:0] m_pick(bit [7:0] p, bit hf);
    if (hf) begin
      for (int i = 7; i >= 0; i--) if (p[i]) return 3'(i);
    end else begin
      for (int i = 0; i < 8; i++) if (p[i]) return 3'(i);
    end
    return 3'd0;
  endfunction

  task automatic m_reset();
    for (int k = 0; k < 2; k++) begin
      m_pend[k] = 8'h00;
      m_busy[k] = 1'b0;
      m_code[k] = 3'd0;
      m_ovf[k]  = 1'b0;
    end
  endtask

  task automatic m_step();
    for (int k = 0; k < 2; k++) begin
      bit [7:0] nxt;
      bit       lost;
      bit       done;
      done = m_busy[k] && rdy;
      lost = 1'b0;
      nxt  = m_pend[k];
      for (int i = 0; i < 8; i++) begin
        bit req;
        bit serviced;
        req      = en && d[i];
        serviced = done && (int'(m_code[k]) == i);
        if (req && m_pend[k][i] && !serviced) lost = 1'b1;
        if (req) nxt[i] = 1'b1;
        else if (serviced) nxt[i] = 1'b0;
      end
      if (lost) m_ovf[k] = 1'b1;
      else if (clr_ovf) m_ovf[k] = 1'b0;
      if (m_busy[k]) begin
        if (rdy) m_busy[k] = 1'b0;
      end else if (m_pend[k] != 8'h00) begin
        m_code[k] = m_pick(m_pend[k], k == 0);
        m_busy[k] = 1'b1;
      end
      m_pend[k] = nxt;
    end
  endtask

  // One clock: model follows the edge, outputs are observed 1 time unit later.
  task automatic tick();
    @(posedge clk);
    if (!rst_n) m_reset();
    else m_step();
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; d = 8'h00; en = 1'b0; rdy = 1'b0; clr_ovf = 1'b0;
    m_reset();
    #12;
    for (int k = 0; k < 2; k++) begin
      n_cmp++;
      if (obs[k] !== 13'd0) begin
        n_bad++;
        $display("FAIL reset_state[%0d]: got %h want %h", k, obs[k], 13'd0);
      end
    end
    rst_n = 1'b1;
    en = 1'b1;
    for (int c = 0; c < 5; c++) begin
      tick();
      n_cmp++;
      if ({v_h, pend_h, ovf_h, v_l, pend_l, ovf_l} !== 20'd0) begin
        n_bad++;
        $display("FAIL idle_quiet cyc %0d: got v/pend/ovf %b_%h_%b %b_%h_%b want all 0",
                 c, v_h, pend_h, ovf_h, v_l, pend_l, ovf_l);
      end
    end
  endtask

  task automatic test_priority_order();
    logic [2:0] got_h[$];
    logic [2:0] got_l[$];
    logic [2:0] want_h[3];
    logic [2:0] want_l[3];
    want_h = '{3'd7, 3'd5, 3'd2};
    want_l = '{3'd2, 3'd5, 3'd7};
    rdy = 1'b1; en = 1'b1; d = 8'b1010_0100;
    tick();
    d = 8'h00;
    for (int c = 0; c < 7; c++) begin
      tick();
      if (v_h) got_h.push_back({a_h, b_h, c_h});
      if (v_l) got_l.push_back({a_l, b_l, c_l});
      for (int k = 0; k < 2; k++) begin
        n_cmp++;
        if (obs[k] !== exp_vec(k)) begin
          n_bad++;
          $display("FAIL order_model[%0d] cyc %0d: got %h want %h", k, c, obs[k], exp_vec(k));
        end
      end
    end
    n_cmp++;
    if (got_h.size() != 3 || got_l.size() != 3) begin
      n_bad++;
      $display("FAIL order_count: got %0d/%0d grants want 3/3", got_h.size(), got_l.size());
    end else begin
      for (int i = 0; i < 3; i++) begin
        n_cmp++;
        if (got_h[i] !== want_h[i] || got_l[i] !== want_l[i]) begin
          n_bad++;
          $display("FAIL order_grant %0d: got %0d/%0d want %0d/%0d",
                   i, got_h[i], got_l[i], want_h[i], want_l[i]);
        end
      end
    end
    n_cmp++;
    if (pend_h !== 8'h00 || pend_l !== 8'h00) begin
      n_bad++;
      $display("FAIL order_drain: got pend %h/%h want 00/00", pend_h, pend_l);
    end
  endtask

  task automatic test_hold();
    rdy = 1'b0; en = 1'b1; d = 8'h08;
    tick();
    d = 8'h00;
    tick();
    d = 8'h40;
    tick();
    d = 8'h00;
    for (int c = 0; c < 3; c++) begin
      tick();
      n_cmp++;
      if ({a_h, b_h, c_h, v_h, a_l, b_l, c_l, v_l} !== 8'b0111_0111 ||
          pend_h !== 8'h48 || pend_l !== 8'h48) begin
        n_bad++;
        $display("FAIL hold_stable cyc %0d: got abcv %b%b%b%b/%b%b%b%b pend %h/%h want 0111 48",
                 c, a_h, b_h, c_h, v_h, a_l, b_l, c_l, v_l, pend_h, pend_l);
      end
    end
    rdy = 1'b1;
    tick();
    n_cmp++;
    if (v_h !== 1'b0 || v_l !== 1'b0 || pend_h !== 8'h40 || pend_l !== 8'h40) begin
      n_bad++;
      $display("FAIL hold_complete: got v %b/%b pend %h/%h want 0/0 40/40",
               v_h, v_l, pend_h, pend_l);
    end
    tick();
    n_cmp++;
    if ({a_h, b_h, c_h, v_h} !== 4'b1101 || {a_l, b_l, c_l, v_l} !== 4'b1101) begin
      n_bad++;
      $display("FAIL hold_next_grant: got abcv %b%b%b%b/%b%b%b%b want 1101",
               a_h, b_h, c_h, v_h, a_l, b_l, c_l, v_l);
    end
    tick();
  endtask

  task automatic test_overflow();
    rdy = 1'b0; en = 1'b1; d = 8'h10;
    tick();
    tick();
    d = 8'h00;
    n_cmp++;
    if (ovf_h !== 1'b1 || ovf_l !== 1'b1 || v_h !== 1'b1 || {a_h, b_h, c_h} !== 3'd4) begin
      n_bad++;
      $display("FAIL ovf_set: got ovf %b/%b v %b code %0d want 1/1 1 4",
               ovf_h, ovf_l, v_h, {a_h, b_h, c_h});
    end
    clr_ovf = 1'b1;
    tick();
    clr_ovf = 1'b0;
    n_cmp++;
    if (ovf_h !== 1'b0 || ovf_l !== 1'b0) begin
      n_bad++;
      $display("FAIL ovf_clear: got %b/%b want 0/0", ovf_h, ovf_l);
    end
    rdy = 1'b1; d = 8'h10;
    tick();
    d = 8'h00;
    n_cmp++;
    if (pend_h !== 8'h10 || pend_l !== 8'h10 || ovf_h !== 1'b0 || ovf_l !== 1'b0 ||
        v_h !== 1'b0) begin
      n_bad++;
      $display("FAIL ovf_set_wins_clear: got pend %h/%h ovf %b/%b v %b want 10/10 0/0 0",
               pend_h, pend_l, ovf_h, ovf_l, v_h);
    end
    // Re-grant 4 and, while it is held, hit it again together with CLR_OVF.
    rdy = 1'b0;
    tick();
    d = 8'h10; clr_ovf = 1'b1;
    tick();
    d = 8'h00; clr_ovf = 1'b0;
    n_cmp++;
    if (ovf_h !== 1'b1 || ovf_l !== 1'b1) begin
      n_bad++;
      $display("FAIL ovf_set_beats_clr: got %b/%b want 1/1", ovf_h, ovf_l);
    end
    rdy = 1'b1; clr_ovf = 1'b1;
    tick();
    tick();
    clr_ovf = 1'b0;
    for (int k = 0; k < 2; k++) begin
      n_cmp++;
      if (obs[k] !== exp_vec(k)) begin
        n_bad++;
        $display("FAIL ovf_model[%0d]: got %h want %h", k, obs[k], exp_vec(k));
      end
    end
  endtask

  task automatic test_reset_mid_grant();
    rdy = 1'b0; en = 1'b1; d = 8'h81;
    tick();
    d = 8'h00;
    tick();
    n_cmp++;
    if (v_h !== 1'b1 || v_l !== 1'b1 || pend_h !== 8'h81 || pend_l !== 8'h81) begin
      n_bad++;
      $display("FAIL midrst_setup: got v %b/%b pend %h/%h want 1/1 81/81",
               v_h, v_l, pend_h, pend_l);
    end
    rdy = 1'b1;
    #2;
    rst_n = 1'b0;
    m_reset();
    #1;
    for (int k = 0; k < 2; k++) begin
      n_cmp++;
      if (obs[k] !== 13'd0) begin
        n_bad++;
        $display("FAIL midrst_async[%0d]: got %h want %h", k, obs[k], 13'd0);
      end
    end
    tick();
    tick();
    rst_n = 1'b1;
    for (int c = 0; c < 4; c++) begin
      tick();
      n_cmp++;
      if (v_h !== 1'b0 || v_l !== 1'b0 || pend_h !== 8'h00 || pend_l !== 8'h00) begin
        n_bad++;
        $display("FAIL midrst_no_grant cyc %0d: got v %b/%b pend %h/%h want 0/0 00/00",
                 c, v_h, v_l, pend_h, pend_l);
      end
    end
  endtask

  task automatic test_random();
    for (int c = 0; c < 400; c++) begin
      d       = ($urandom_range(0, 2) == 0) ? 8'($urandom) : 8'h00;
      en      = ($urandom_range(0, 3) != 0);
      rdy     = ($urandom_range(0, 1) == 1);
      clr_ovf = ($urandom_range(0, 7) == 0);
      tick();
      for (int k = 0; k < 2; k++) begin
        n_cmp++;
        if (obs[k] !== exp_vec(k)) begin
          n_bad++;
          $display("FAIL random_model[%0d] cyc %0d: got %h want %h", k, c, obs[k], exp_vec(k));
        end
      end
    end
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    test_reset();
    test_priority_order();
    test_hold();
    test_overflow();
    test_reset_mid_grant();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
